// File: rtl/fc_act_loader_if.sv
// Stream bundle for fc_act_loader: activation beats in, requantised result out.
//   in_valid/in_ready/in_data     : activation stream into the loader
//   out_valid/out_ready/out_data  : requantised result stream to the next layer
//   out_raw                       : unmodified sampled layer result
// slave  = loader side, master = producer/consumer side.
interface fc_act_loader_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned ZW    = 22
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [ZW-1:0]    out_raw;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_raw
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_raw
  );
endinterface

// File: rtl/fc_act_loader.sv
// Front-end sequencer for a fully-connected layer. Fills an IN-entry
// activation bank from a valid/ready stream, holds it for SETTLE cycles
// while the combinational layer settles, samples the ReLU result z,
// requantises it (round half up, right shift, saturate) and offers it
// downstream.
//   clk, rst_n : clock, asynchronous active-low reset
//   io         : activation input stream and result output stream
//   x          : register bank driving the layer's parallel input
//   z          : layer ReLU result (unsigned)
//   busy       : high whenever not accepting activations
module fc_act_loader #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned IN     = 128,
  parameter int unsigned ZW     = 22,
  parameter int unsigned SETTLE = 2,
  parameter int unsigned SHIFT  = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  fc_act_loader_if.slave   io,
  output logic [WIDTH-1:0] x [0:IN-1],
  input  logic [ZW-1:0]    z,
  output logic             busy
);
  localparam int unsigned IDX_W = (IN > 1) ? $clog2(IN) : 1;
  localparam int unsigned CNT_W = 4;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(IN - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);
  // Half-LSB rounding constant; zero when no shift is applied.
  localparam logic [ZW:0] RND  = (SHIFT > 0) ? ((ZW+1)'(1) << (SHIFT - 1)) : '0;
  localparam logic [ZW:0] QMAX = (ZW+1)'((2 ** WIDTH) - 1);

  typedef enum logic [1:0] {S_FILL, S_SETTLE, S_OUT} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wr_en, smp_en;
  logic [ZW:0]      r_c, q_c;
  logic [WIDTH-1:0] qsat_c;

  // Handshake-side flags come straight from the state register.
  assign io.in_ready  = (state_q == S_FILL);
  assign io.out_valid = (state_q == S_OUT);
  assign busy         = (state_q != S_FILL);

  // State, index and settle counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FILL;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and strobe decode.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    wr_en   = 1'b0;
    smp_en  = 1'b0;
    case (state_q)
      S_FILL: begin
        if (io.in_valid) begin
          wr_en = 1'b1;
          idx_d = idx_q + IDX_W'(1);
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
            cnt_d   = '0;
            state_d = S_SETTLE;
          end
        end
      end
      S_SETTLE: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          smp_en  = 1'b1;
          cnt_d   = '0;
          state_d = S_OUT;
        end
      end
      S_OUT: begin
        if (io.out_ready) begin
          idx_d   = '0;
          state_d = S_FILL;
        end
      end
      default: state_d = S_FILL;
    endcase
  end

  // Requantise: add half LSB in ZW+1 bits, shift, saturate to WIDTH.
  always_comb begin
    r_c    = {1'b0, z} + RND;
    q_c    = r_c >> SHIFT;
    qsat_c = (q_c > QMAX) ? {WIDTH{1'b1}} : q_c[WIDTH-1:0];
  end

  // Activation bank; only written on an accepted beat in FILL.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < IN; i++) x[i] <= '0;
    end else if (wr_en) begin
      x[idx_q] <= io.in_data;
    end
  end

  // Result registers; updated only at the sample edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      io.out_data <= '0;
      io.out_raw  <= '0;
    end else if (smp_en) begin
      io.out_data <= qsat_c;
      io.out_raw  <= z;
    end
  end
endmodule

// File: tb/tb_fc_act_loader.sv
module tb_fc_act_loader;
  localparam int unsigned WIDTH  = 8;
  localparam int unsigned IN     = 128;
  localparam int unsigned ZW     = 22;
  localparam int unsigned SETTLE = 2;
  localparam int unsigned SHIFT  = 6;

  logic             clk   = 1'b0;
  logic             rst_n = 1'b0;
  logic [ZW-1:0]    z     = '0;
  logic             busy;
  logic [WIDTH-1:0] x [0:IN-1];

  fc_act_loader_if #(.WIDTH(WIDTH), .ZW(ZW)) bus ();

  fc_act_loader #(
    .WIDTH(WIDTH), .IN(IN), .ZW(ZW), .SETTLE(SETTLE), .SHIFT(SHIFT)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .io   (bus),
    .x    (x),
    .z    (z),
    .busy (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [WIDTH-1:0] d;
    logic [ZW-1:0]    raw;
  } exp_t;

  exp_t             sbq [$];
  logic [WIDTH-1:0] vec [0:IN-1];
  int               checks = 0;
  int               errors = 0;

  // Reference requantiser: round half up by 2^(SHIFT-1), divide by 2^SHIFT, clip at 255.
  function automatic logic [WIDTH-1:0] model(input logic [ZW-1:0] zz);
    longint q;
    q = (longint'(zz) + 32) / 64;
    return (q > 255) ? 8'd255 : 8'(q);
  endfunction

  task automatic rand_vec();
    for (int i = 0; i < IN; i++) vec[i] = 8'($urandom);
  endtask

  // Send vec[0..nb-1]; returns at the negedge right after the last accepting edge.
  task automatic fill(input int duty, input int nb);
    int n = 0;
    int guard = 0;
    while (n < nb) begin
      @(negedge clk);
      guard++;
      if (guard > 20000) begin
        checks++; errors++;
        $display("FAIL fill_timeout accepted=%0d required=%0d", n, nb);
        break;
      end
      bus.in_valid = ($urandom_range(99) < duty);
      bus.in_data  = bus.in_valid ? vec[n] : 8'($urandom);
      if (bus.in_valid && bus.in_ready) n++;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  // Push the expected result for z, then stream the vector.
  task automatic load(input logic [ZW-1:0] zv, input int duty);
    z = zv;
    sbq.push_back('{d: model(zv), raw: zv});
    fill(duty, IN);
  endtask

  // Cycles from the last accept until out_valid is seen.
  task automatic wait_valid(output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 64) begin
      @(negedge clk);
      lat++;
    end
  endtask

  // Take one result; ok=0 on timeout or empty scoreboard. Ends one cycle after the handshake.
  task automatic consume(output exp_t e, output logic [WIDTH-1:0] gd,
                         output logic [ZW-1:0] gr, output bit ok);
    int g = 0;
    ok = 1'b0;
    e = '0; gd = '0; gr = '0;
    bus.out_ready = 1'b1;
    while (!bus.out_valid && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (bus.out_valid && sbq.size() > 0) begin
      e  = sbq.pop_front();
      gd = bus.out_data;
      gr = bus.out_raw;
      ok = 1'b1;
    end
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    exp_t e;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    rand_vec();
    load(22'd5000, 100);
    repeat (SETTLE + 2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.in_ready, bus.out_valid, busy} !== 3'b100) begin
      errors++;
      $display("FAIL reset_flags got ready/valid/busy=%b required=100",
               {bus.in_ready, bus.out_valid, busy});
    end
    checks++;
    if (bus.out_data !== 8'd0 || bus.out_raw !== 22'd0) begin
      errors++;
      $display("FAIL reset_out got data=%0d raw=%0d required 0/0", bus.out_data, bus.out_raw);
    end
    for (int i = 0; i < IN; i++) begin
      checks++;
      if (x[i] !== 8'd0) begin
        errors++;
        $display("FAIL reset_x[%0d] got=%0d required=0", i, x[i]);
      end
    end
    while (sbq.size() > 0) e = sbq.pop_front();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_full_fill();
    exp_t e; logic [WIDTH-1:0] gd; logic [ZW-1:0] gr; bit ok; int lat;
    for (int i = 0; i < IN; i++) vec[i] = 8'(i);
    load(22'd123456, 100);
    checks++;
    if (bus.in_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL fill_ready_fall got ready=%b busy=%b required 0/1", bus.in_ready, busy);
    end
    wait_valid(lat);
    checks++;
    if (lat != SETTLE) begin
      errors++;
      $display("FAIL fill_latency got=%0d required=%0d", lat, SETTLE);
    end
    for (int i = 0; i < IN; i++) begin
      checks++;
      if (x[i] !== 8'(i)) begin
        errors++;
        $display("FAIL fill_x[%0d] got=%0d required=%0d", i, x[i], i);
      end
    end
    consume(e, gd, gr, ok);
    checks++;
    if (!ok || gr !== 22'd123456 || gd !== e.d) begin
      errors++;
      $display("FAIL fill_result ok=%0d got data=%0d raw=%0d required data=%0d raw=123456",
               ok, gd, gr, e.d);
    end
  endtask

  task automatic test_requant();
    logic [ZW-1:0]    zs [0:4];
    logic [WIDTH-1:0] ds [0:4];
    exp_t e; logic [WIDTH-1:0] gd; logic [ZW-1:0] gr; bit ok; int lat;
    zs = '{22'd0, 22'd100, 22'd16320, 22'd16352, 22'h3FFFFF};
    ds = '{8'd0, 8'd2, 8'd255, 8'd255, 8'd255};
    for (int k = 0; k < 5; k++) begin
      rand_vec();
      load(zs[k], 100);
      wait_valid(lat);
      consume(e, gd, gr, ok);
      checks++;
      if (!ok || gd !== ds[k]) begin
        errors++;
        $display("FAIL requant_data z=%0d ok=%0d got=%0d required=%0d", zs[k], ok, gd, ds[k]);
      end
      checks++;
      if (gr !== zs[k]) begin
        errors++;
        $display("FAIL requant_raw got=%0d required=%0d", gr, zs[k]);
      end
    end
  endtask

  task automatic test_backpressure();
    exp_t e; logic [WIDTH-1:0] gd; logic [ZW-1:0] gr; bit ok; int lat;
    exp_t head;
    rand_vec();
    load(22'd40000, 100);
    wait_valid(lat);
    head = sbq[0];
    bus.out_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'($urandom);
      @(negedge clk);
      checks++;
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
        errors++;
        $display("FAIL bp_flags cyc=%0d got ready=%b valid=%b required 0/1",
                 c, bus.in_ready, bus.out_valid);
      end
      checks++;
      if (bus.out_data !== head.d || bus.out_raw !== head.raw) begin
        errors++;
        $display("FAIL bp_hold cyc=%0d got data=%0d raw=%0d required data=%0d raw=%0d",
                 c, bus.out_data, bus.out_raw, head.d, head.raw);
      end
      for (int i = 0; i < IN; i++) begin
        checks++;
        if (x[i] !== vec[i]) begin
          errors++;
          $display("FAIL bp_x[%0d] cyc=%0d got=%0d required=%0d", i, c, x[i], vec[i]);
        end
      end
    end
    bus.in_valid = 1'b0;
    consume(e, gd, gr, ok);
    checks++;
    if (!ok || gd !== e.d || gr !== e.raw) begin
      errors++;
      $display("FAIL bp_result ok=%0d got data=%0d raw=%0d required data=%0d raw=%0d",
               ok, gd, gr, e.d, e.raw);
    end
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_release got ready=%b valid=%b required 1/0", bus.in_ready, bus.out_valid);
    end
    rand_vec();
    load(22'd777, 100);
    wait_valid(lat);
    for (int i = 0; i < IN; i++) begin
      checks++;
      if (x[i] !== vec[i]) begin
        errors++;
        $display("FAIL bp_next_x[%0d] got=%0d required=%0d", i, x[i], vec[i]);
      end
    end
    consume(e, gd, gr, ok);
    checks++;
    if (!ok || gd !== e.d || gr !== e.raw) begin
      errors++;
      $display("FAIL bp_next_result ok=%0d got=%0d required=%0d", ok, gd, e.d);
    end
  endtask

  task automatic test_gapped();
    exp_t e; logic [WIDTH-1:0] gd; logic [ZW-1:0] gr; bit ok; int lat;
    for (int v = 0; v < 2; v++) begin
      rand_vec();
      load(22'($urandom), 40);
      wait_valid(lat);
      checks++;
      if (lat != SETTLE) begin
        errors++;
        $display("FAIL gap_latency got=%0d required=%0d", lat, SETTLE);
      end
      for (int i = 0; i < IN; i++) begin
        checks++;
        if (x[i] !== vec[i]) begin
          errors++;
          $display("FAIL gap_x[%0d] got=%0d required=%0d", i, x[i], vec[i]);
        end
      end
      consume(e, gd, gr, ok);
      checks++;
      if (!ok || gd !== e.d || gr !== e.raw) begin
        errors++;
        $display("FAIL gap_result ok=%0d got data=%0d raw=%0d required data=%0d raw=%0d",
                 ok, gd, gr, e.d, e.raw);
      end
    end
  endtask

  task automatic test_reset_mid_fill();
    exp_t e; logic [WIDTH-1:0] gd; logic [ZW-1:0] gr; bit ok; int lat;
    for (int i = 0; i < IN; i++) vec[i] = 8'hA5;
    fill(100, 50);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midrst_flags got ready=%b busy=%b required 1/0", bus.in_ready, busy);
    end
    for (int i = 0; i < IN; i++) begin
      checks++;
      if (x[i] !== 8'd0) begin
        errors++;
        $display("FAIL midrst_x[%0d] got=%0d required=0", i, x[i]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < IN; i++) vec[i] = 8'(IN - 1 - i);
    load(22'd9999, 100);
    wait_valid(lat);
    checks++;
    if (lat != SETTLE) begin
      errors++;
      $display("FAIL midrst_latency got=%0d required=%0d", lat, SETTLE);
    end
    for (int i = 0; i < IN; i++) begin
      checks++;
      if (x[i] !== vec[i]) begin
        errors++;
        $display("FAIL midrst_x_new[%0d] got=%0d required=%0d", i, x[i], vec[i]);
      end
    end
    consume(e, gd, gr, ok);
    checks++;
    if (!ok || gd !== e.d || gr !== 22'd9999) begin
      errors++;
      $display("FAIL midrst_result ok=%0d got data=%0d raw=%0d required data=%0d raw=9999",
               ok, gd, gr, e.d);
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_full_fill();
    test_requant();
    test_backpressure();
    test_gapped();
    test_reset_mid_fill();
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover got=%0d required=0", sbq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
